vram_dbuf_bank: RTL and testbench

Parametrised, double-buffered VRAM bank that generalises the fixed single-copy tile, pattern, palette and sprite RAMs into one reusable block. It holds two physical banks of `2**ADDR_W` words each. The PPU reads the front bank while the CPU writes the back bank with byte enables. A swap handshake, intended for vblank, exchanges the two banks, and an optional sync engine then copies the new front into the new back so the CPU resumes from a consistent image. One instance per VRAM region (tile, pattern, palette, sprite) replaces the current single-copy RAMs.

---
 rtl/vram_dbuf_bank_if.sv | 31 +++
 rtl/vram_dbuf_bank.sv | 172 +++++++++++++++++
 tb/tb_vram_dbuf_bank.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dbuf_bank_if.sv
// vram_dbuf_bank_if
// Bundles the PPU read port, the CPU back-bank port and the swap handshake of
// one double-buffered VRAM bank.
//   master : drives addresses, write data/strobes and swap_req (CPU/PPU side)
//   slave  : returns read data, cpu_ready, swap_ack and front_sel (the bank)
interface vram_dbuf_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   ppu_addr;
  logic [DATA_W-1:0]   ppu_rddata;
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_wren;
  logic [DATA_W/8-1:0] cpu_byteena;
  logic [DATA_W-1:0]   cpu_wrdata;
  logic [DATA_W-1:0]   cpu_rddata;
  logic                cpu_ready;
  logic                swap_req;
  logic                swap_ack;
  logic                front_sel;

  modport master (
    output ppu_addr, cpu_addr, cpu_wren, cpu_byteena, cpu_wrdata, swap_req,
    input  ppu_rddata, cpu_rddata, cpu_ready, swap_ack, front_sel
  );

  modport slave (
    input  ppu_addr, cpu_addr, cpu_wren, cpu_byteena, cpu_wrdata, swap_req,
    output ppu_rddata, cpu_rddata, cpu_ready, swap_ack, front_sel
  );
endinterface

// File: rtl/vram_dbuf_bank.sv
// vram_dbuf_bank
// Two physical RAM banks of 2**ADDR_W words. The PPU reads the front bank, the
// CPU reads/writes the back bank with byte enables. A swap exchanges the banks
// and, when SYNC_ON_SWAP is set, copies the new front into the new back while
// the CPU is held off (cpu_ready low).
// Ports:
//   clk    : single clock
//   rst_n  : asynchronous active-low reset (RAM contents are kept)
//   bus    : vram_dbuf_bank_if.slave (PPU port, CPU port, swap handshake)
module vram_dbuf_bank #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int SYNC_ON_SWAP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vram_dbuf_bank_if.slave bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  // Counter spans 0..DEPTH so the final write of word DEPTH-1 happens.
  localparam logic [ADDR_W:0] CNT_LAST = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic                front_sel_r, front_sel_s;
  logic                swap_ack_r, swap_ack_s;
  logic                cpu_ready_r, cpu_ready_s;
  logic [ADDR_W:0]     cnt_r, cnt_s;

  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [NBYTES-1:0]   wr_be_s;
  logic [DATA_W-1:0]   wr_data_s;

  logic [DATA_W-1:0]   mem0 [DEPTH];
  logic [DATA_W-1:0]   mem1 [DEPTH];
  logic [DATA_W-1:0]   ppu_rd_r;
  logic [DATA_W-1:0]   cpu_rd_r;
  logic [DATA_W-1:0]   copy_rd_r;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      front_sel_r <= 1'b0;
      swap_ack_r  <= 1'b0;
      cpu_ready_r <= 1'b1;
      cnt_r       <= CNT_ZERO;
    end else begin
      state_r     <= state_s;
      front_sel_r <= front_sel_s;
      swap_ack_r  <= swap_ack_s;
      cpu_ready_r <= cpu_ready_s;
      cnt_r       <= cnt_s;
    end
  end

  // Next-state logic: swaps are only taken in IDLE; COPY walks the counter.
  always_comb begin
    state_s     = state_r;
    front_sel_s = front_sel_r;
    swap_ack_s  = 1'b0;
    cpu_ready_s = cpu_ready_r;
    cnt_s       = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.swap_req) begin
          front_sel_s = ~front_sel_r;
          swap_ack_s  = 1'b1;
          if (SYNC_ON_SWAP != 0) begin
            state_s     = ST_COPY;
            cpu_ready_s = 1'b0;
            cnt_s       = CNT_ZERO;
          end else begin
            state_s     = ST_IDLE;
            cpu_ready_s = 1'b1;
          end
        end else begin
          cpu_ready_s = 1'b1;
        end
      end
      ST_COPY: begin
        if (cnt_r == CNT_LAST) begin
          state_s     = ST_IDLE;
          cpu_ready_s = 1'b1;
          cnt_s       = CNT_ZERO;
        end else begin
          cpu_ready_s = 1'b0;
          cnt_s       = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cpu_ready_s = 1'b1;
        cnt_s       = CNT_ZERO;
      end
    endcase
  end

  // Back-bank write port: CPU in IDLE, copy engine (one word behind its read) in COPY.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_W{1'b0}};
    wr_be_s   = {NBYTES{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        wr_en_s   = bus.cpu_wren;
        wr_addr_s = bus.cpu_addr;
        wr_be_s   = bus.cpu_byteena;
        wr_data_s = bus.cpu_wrdata;
      end
      ST_COPY: begin
        wr_en_s   = (cnt_r != CNT_ZERO);
        wr_addr_s = cnt_r[ADDR_W-1:0] - ADDR_W'(1'b1);
        wr_be_s   = {NBYTES{1'b1}};
        wr_data_s = copy_rd_r;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Bank 0 write: only while bank 0 is the back bank (front_sel = 1).
  always_ff @(posedge clk) begin
    if (wr_en_s && front_sel_r) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be_s[i]) begin
          mem0[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // Bank 1 write: only while bank 1 is the back bank (front_sel = 0).
  always_ff @(posedge clk) begin
    if (wr_en_s && !front_sel_r) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be_s[i]) begin
          mem1[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // Registered reads: PPU and copy engine from the front, CPU from the back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_rd_r  <= {DATA_W{1'b0}};
      cpu_rd_r  <= {DATA_W{1'b0}};
      copy_rd_r <= {DATA_W{1'b0}};
    end else begin
      ppu_rd_r  <= front_sel_r ? mem1[bus.ppu_addr] : mem0[bus.ppu_addr];
      cpu_rd_r  <= front_sel_r ? mem0[bus.cpu_addr] : mem1[bus.cpu_addr];
      copy_rd_r <= front_sel_r ? mem1[cnt_r[ADDR_W-1:0]] : mem0[cnt_r[ADDR_W-1:0]];
    end
  end

  assign bus.ppu_rddata = ppu_rd_r;
  assign bus.cpu_rddata = cpu_rd_r;
  assign bus.cpu_ready  = cpu_ready_r;
  assign bus.swap_ack   = swap_ack_r;
  assign bus.front_sel  = front_sel_r;
endmodule

// File: tb/tb_vram_dbuf_bank.sv
// tb_vram_dbuf_bank
// Drives one synced (SYNC_ON_SWAP=1) and one unsynced (SYNC_ON_SWAP=0) bank,
// DATA_W=32, ADDR_W=4, from shared stimulus. A bank-level reference model
// (two word arrays, a front index and a busy countdown) predicts every output.
module tb_vram_dbuf_bank;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  logic [AW-1:0] ppu_addr, cpu_addr;
  logic          cpu_wren, swap_req;
  logic [3:0]    cpu_byteena;
  logic [DW-1:0] cpu_wrdata;

  vram_dbuf_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();
  vram_dbuf_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  assign bus_s.ppu_addr = ppu_addr;    assign bus_n.ppu_addr = ppu_addr;
  assign bus_s.cpu_addr = cpu_addr;    assign bus_n.cpu_addr = cpu_addr;
  assign bus_s.cpu_wren = cpu_wren;    assign bus_n.cpu_wren = cpu_wren;
  assign bus_s.cpu_byteena = cpu_byteena; assign bus_n.cpu_byteena = cpu_byteena;
  assign bus_s.cpu_wrdata = cpu_wrdata; assign bus_n.cpu_wrdata = cpu_wrdata;
  assign bus_s.swap_req = swap_req;    assign bus_n.swap_req = swap_req;

  vram_dbuf_bank #(.DATA_W(DW), .ADDR_W(AW), .SYNC_ON_SWAP(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  vram_dbuf_bank #(.DATA_W(DW), .ADDR_W(AW), .SYNC_ON_SWAP(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference model, index [dut][bank][addr]; dut 0 = synced, 1 = unsynced
  logic [31:0] mb [2][2][DEPTH];
  int mfront [2];
  int mbusy [2];

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } be_vec_t;
  be_vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mfront[d] = 0;
      mbusy[d] = 0;
    end
  endtask

  task automatic cmp_dut(input string tag, input int d, input logic fs, input logic ack,
                         input logic rdy, input logic [31:0] ppu, input logic [31:0] cpu,
                         input logic [31:0] e_ppu, input logic [31:0] e_cpu,
                         input bit e_cv, input bit e_ack);
    chk({tag, "_front_sel"}, {31'd0, fs}, 32'(mfront[d]));
    chk({tag, "_swap_ack"}, {31'd0, ack}, {31'd0, e_ack});
    chk({tag, "_cpu_ready"}, {31'd0, rdy}, {31'd0, (mbusy[d] == 0)});
    chk({tag, "_ppu_rddata"}, ppu, e_ppu);
    if (e_cv) chk({tag, "_cpu_rddata"}, cpu, e_cpu);
  endtask

  // One clock: update the model from the current inputs, then compare outputs.
  task automatic step();
    logic [31:0] e_ppu [2];
    logic [31:0] e_cpu [2];
    bit e_cv [2];
    bit e_ack [2];
    for (int d = 0; d < 2; d++) begin
      int f;
      int b;
      f = mfront[d];
      b = 1 - f;
      e_ppu[d] = mb[d][f][ppu_addr];
      e_cpu[d] = mb[d][b][cpu_addr];
      e_cv[d] = (mbusy[d] == 0);
      e_ack[d] = 1'b0;
      if (mbusy[d] == 0) begin
        if (cpu_wren) mb[d][b][cpu_addr] = merge(mb[d][b][cpu_addr], cpu_wrdata, cpu_byteena);
        if (swap_req) begin
          mfront[d] = b;
          e_ack[d] = 1'b1;
          if (d == 0) begin
            for (int a = 0; a < DEPTH; a++) mb[d][f][a] = mb[d][b][a];
            mbusy[d] = DEPTH + 1;
          end
        end
      end else begin
        mbusy[d]--;
      end
    end
    @(posedge clk);
    #1;
    if (chk_en) begin
      cmp_dut("sync", 0, bus_s.front_sel, bus_s.swap_ack, bus_s.cpu_ready, bus_s.ppu_rddata,
              bus_s.cpu_rddata, e_ppu[0], e_cpu[0], e_cv[0], e_ack[0]);
      cmp_dut("nosync", 1, bus_n.front_sel, bus_n.swap_ack, bus_n.cpu_ready, bus_n.ppu_rddata,
              bus_n.cpu_rddata, e_ppu[1], e_cpu[1], e_cv[1], e_ack[1]);
    end
  endtask

  task automatic fill_back_random();
    for (int a = 0; a < DEPTH; a++) begin
      cpu_wren = 1'b1; cpu_byteena = 4'hF; cpu_addr = 4'(a); cpu_wrdata = $urandom;
      step();
    end
    cpu_wren = 1'b0;
  endtask

  task automatic do_swap_and_settle();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (20) step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_front_sel"}, {31'd0, bus_s.front_sel}, 32'd0);
    chk({tag, "_s_swap_ack"}, {31'd0, bus_s.swap_ack}, 32'd0);
    chk({tag, "_s_cpu_ready"}, {31'd0, bus_s.cpu_ready}, 32'd1);
    chk({tag, "_n_front_sel"}, {31'd0, bus_n.front_sel}, 32'd0);
    chk({tag, "_n_swap_ack"}, {31'd0, bus_n.swap_ack}, 32'd0);
    chk({tag, "_n_cpu_ready"}, {31'd0, bus_n.cpu_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a_val [DEPTH];
    logic [31:0] f_val [DEPTH];
    int cnt;
    int hit;

    tbl[0] = '{4'd3, 4'b1111, 32'hAABBCCDD, 32'hAABBCCDD};
    tbl[1] = '{4'd3, 4'b0101, 32'h11223344, 32'hAA22CC44};
    tbl[2] = '{4'd7, 4'b1111, 32'h00000000, 32'h00000000};
    tbl[3] = '{4'd7, 4'b1010, 32'hFFFFFFFF, 32'hFF00FF00};
    tbl[4] = '{4'd7, 4'b0001, 32'h12345678, 32'hFF00FF78};
    tbl[5] = '{4'd7, 4'b0000, 32'hFFFFFFFF, 32'hFF00FF78};

    ppu_addr = '0; cpu_addr = '0; cpu_wren = 1'b0; swap_req = 1'b0;
    cpu_byteena = 4'h0; cpu_wrdata = '0;
    model_reset();

    // power-on reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // swap, then asynchronous reset mid-cycle must restore reset values at once
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("pre_rst_n_front_sel", {31'd0, bus_n.front_sel}, 32'd1);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    #1 rst_n = 1'b1;

    // make both physical banks of both instances known to the model
    fill_back_random();
    do_swap_and_settle();
    fill_back_random();
    do_swap_and_settle();
    chk_en = 1'b1;

    // byte-enable write table
    foreach (tbl[k]) begin
      cpu_wren = 1'b1; cpu_addr = tbl[k].addr; cpu_byteena = tbl[k].be; cpu_wrdata = tbl[k].wdata;
      step();
      cpu_wren = 1'b0;
      step();
      chk($sformatf("be_tbl%0d_sync", k), bus_s.cpu_rddata, tbl[k].exp);
      chk($sformatf("be_tbl%0d_nosync", k), bus_n.cpu_rddata, tbl[k].exp);
    end

    // swap without sync
    cpu_wren = 1'b1; cpu_addr = 4'd0; cpu_byteena = 4'hF; cpu_wrdata = 32'h5;
    step();
    cpu_wren = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("nosync_ack", {31'd0, bus_n.swap_ack}, 32'd1);
    chk("nosync_front", {31'd0, bus_n.front_sel}, 32'd1);
    ppu_addr = 4'd0;
    step();
    chk("nosync_ack_pulse", {31'd0, bus_n.swap_ack}, 32'd0);
    chk("nosync_ppu_new_front", bus_n.ppu_rddata, 32'h5);
    repeat (20) step();

    // swap with sync: cpu_ready low for DEPTH+1 cycles, copy covers the last word
    for (int i = 0; i < DEPTH; i++) begin
      cpu_wren = 1'b1; cpu_byteena = 4'hF; cpu_addr = 4'(i); cpu_wrdata = 32'(i + 32'h100);
      step();
    end
    cpu_wren = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_s.cpu_ready) break;
      cnt++;
      step();
    end
    chk("sync_ready_low_cycles", 32'(cnt), 32'd17);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_addr = 4'(i);
      step();
      chk($sformatf("sync_copy_addr%0d", i), bus_s.cpu_rddata, 32'(i + 32'h100));
    end

    // held request with a dropped write during COPY
    swap_req = 1'b1;
    step();
    chk("held_first_ack", {31'd0, bus_s.swap_ack}, 32'd1);
    hit = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        cpu_wren = 1'b1; cpu_addr = 4'd2; cpu_byteena = 4'hF; cpu_wrdata = 32'h0000DEAD;
      end
      step();
      cpu_wren = 1'b0;
      if (bus_s.swap_ack) begin
        hit = k;
        break;
      end
    end
    chk("held_second_ack_delay", 32'(hit), 32'd18);
    swap_req = 1'b0;
    repeat (20) step();
    cpu_addr = 4'd2;
    step();
    chk("copy_write_dropped", bus_s.cpu_rddata, 32'h102);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      ppu_addr = 4'($urandom_range(0, 15));
      cpu_addr = 4'($urandom_range(0, 15));
      cpu_wren = ($urandom_range(0, 2) == 0);
      cpu_byteena = 4'($urandom_range(0, 15));
      cpu_wrdata = $urandom;
      swap_req = ($urandom_range(0, 9) == 0);
      step();
    end
    cpu_wren = 1'b0; swap_req = 1'b0;
    repeat (20) step();

    // reset at copy cycle 7: words 0..5 copied, 6..15 untouched
    if (mfront[0] == 0) do_swap_and_settle();
    for (int i = 0; i < DEPTH; i++) begin
      a_val[i] = $urandom;
      cpu_wren = 1'b1; cpu_byteena = 4'hF; cpu_addr = 4'(i); cpu_wrdata = a_val[i];
      step();
    end
    cpu_wren = 1'b0;
    for (int i = 0; i < DEPTH; i++) f_val[i] = mb[0][1][i];
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (7) step();
    #2 rst_n = 1'b0;
    chk_en = 1'b0;
    #1 check_reset_values("midcopy");
    #1 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_addr = 4'(i);
      step();
      chk($sformatf("midcopy_addr%0d", i), bus_s.cpu_rddata, (i < 6) ? a_val[i] : f_val[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
